// File: rtl/shapool_result_collector_if.sv
// Core-side and daisy-chain signals of the shapool result collector.
// The collector connects through the slave modport; the driver of its inputs uses master.
interface shapool_result_collector_if #(
  parameter int POOL_SIZE   = 4,
  parameter int NONCE_WIDTH = 32
);
  logic                              start_in;
  logic [POOL_SIZE-1:0]              core_success_in;
  logic [POOL_SIZE*NONCE_WIDTH-1:0]  core_nonce_in;
  logic                              halt_out;
  logic                              ready_n_out;
  logic                              ready_oe_out;
  logic                              cs_n_in;
  logic                              sck_rise_in;
  logic                              sdi_in;
  logic                              sdo_out;
  logic                              status_led_n_out;

  modport master (
    output start_in, core_success_in, core_nonce_in, cs_n_in, sck_rise_in, sdi_in,
    input  halt_out, ready_n_out, ready_oe_out, sdo_out, status_led_n_out
  );

  modport slave (
    input  start_in, core_success_in, core_nonce_in, cs_n_in, sck_rise_in, sdi_in,
    output halt_out, ready_n_out, ready_oe_out, sdo_out, status_led_n_out
  );
endinterface

// File: rtl/shapool_result_collector.sv
// Arms the hashing pool, latches the lowest-index winner and shifts it out on the daisy chain.
// Optional run timeout: define SHAPOOL_TIMEOUT_EN.
module shapool_result_collector #(
  parameter int POOL_SIZE      = 4,
  parameter int POOL_SIZE_LOG2 = 2,
  parameter int NONCE_WIDTH    = 32,
  parameter int LED_DIV_LOG2   = 22,
  parameter int TIMEOUT_LOG2   = 32
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  shapool_result_collector_if.slave bus
);
  localparam int W = 1 + POOL_SIZE_LOG2 + NONCE_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic                      found;
  logic [POOL_SIZE_LOG2-1:0] win_idx;
  logic [NONCE_WIDTH-1:0]    win_nonce;
  logic                      halt;
  logic                      ready_oe;
  logic                      led_n;
  logic [LED_DIV_LOG2-1:0]   led_cnt;
  logic [W-1:0]              shreg;
  logic                      cs_n_q;

  logic                      hit;
  logic [POOL_SIZE_LOG2-1:0] hit_idx;
  logic [NONCE_WIDTH-1:0]    hit_nonce;
  logic                      tmo_hit;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    hit       = |bus.core_success_in;
    hit_idx   = '0;
    hit_nonce = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      if (bus.core_success_in[i]) begin
        hit_idx   = POOL_SIZE_LOG2'(i);
        hit_nonce = bus.core_nonce_in[i*NONCE_WIDTH +: NONCE_WIDTH];
      end
    end
  end

`ifdef SHAPOOL_TIMEOUT_EN
  logic [TIMEOUT_LOG2-1:0] tmo_cnt;

  always_ff @(posedge clk_in) begin
    if (reset_in || state != RUN || bus.start_in) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + TIMEOUT_LOG2'(1);
  end

  assign tmo_hit = (tmo_cnt + TIMEOUT_LOG2'(1)) == {TIMEOUT_LOG2{1'b1}};
`else
  assign tmo_hit = 1'b0;
  if (TIMEOUT_LOG2 > 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state     <= IDLE;
      found     <= 1'b0;
      win_idx   <= '0;
      win_nonce <= '0;
      halt      <= 1'b1;
      ready_oe  <= 1'b0;
      led_n     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          halt     <= 1'b1;
          ready_oe <= 1'b0;
          led_n    <= 1'b1;
          if (bus.start_in) begin
            state     <= RUN;
            found     <= 1'b0;
            win_idx   <= '0;
            win_nonce <= '0;
            halt      <= 1'b0;
            led_n     <= led_cnt[LED_DIV_LOG2-1];
          end
        end
        RUN: begin
          led_n <= led_cnt[LED_DIV_LOG2-1];
          // A restart discards any success seen in the same cycle.
          if (bus.start_in) begin
            found     <= 1'b0;
            win_idx   <= '0;
            win_nonce <= '0;
          end else if (hit || tmo_hit) begin
            state    <= DONE;
            halt     <= 1'b1;
            ready_oe <= 1'b1;
            led_n    <= 1'b0;
            if (hit) begin
              found     <= 1'b1;
              win_idx   <= hit_idx;
              win_nonce <= hit_nonce;
            end
          end
        end
        DONE: begin
          if (bus.start_in) begin
            state     <= RUN;
            found     <= 1'b0;
            win_idx   <= '0;
            win_nonce <= '0;
            halt      <= 1'b0;
            ready_oe  <= 1'b0;
            led_n     <= led_cnt[LED_DIV_LOG2-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) led_cnt <= '0;
    else          led_cnt <= led_cnt + LED_DIV_LOG2'(1);
  end

  // Frame loads from the registered capture, so a same-cycle capture waits for the next load.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      shreg  <= '0;
      cs_n_q <= 1'b1;
    end else begin
      cs_n_q <= bus.cs_n_in;
      if (cs_n_q && !bus.cs_n_in)
        shreg <= {found, win_idx, win_nonce};
      else if (!bus.cs_n_in && bus.sck_rise_in)
        shreg <= {shreg[W-2:0], bus.sdi_in};
    end
  end

  assign bus.halt_out         = halt;
  assign bus.ready_oe_out     = ready_oe;
  assign bus.ready_n_out      = 1'b0;
  assign bus.sdo_out          = shreg[W-1];
  assign bus.status_led_n_out = led_n;
endmodule
